// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART_TX among NUM_REQ byte requesters.
// Optional WAIT_FIN watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 in_Clk,
    input  logic                 in_Reset,
    input  logic [NUM_REQ-1:0]   in_Req,
    input  logic [8*NUM_REQ-1:0] in_Req_Byte,
    output logic [NUM_REQ-1:0]   out_Grant,
    output logic [NUM_REQ-1:0]   out_Done,
    output logic                 out_TX_EN,
    output logic [7:0]           out_TX_Byte,
    input  logic                 in_TX_Finish,
    output logic                 out_Busy,
    output logic                 out_Timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_FIN,
        S_RELEASE
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic               tx_en_q;
    logic [7:0]         tx_byte_q;
    logic               busy_q;

    logic               win_vld_d;
    logic [IDX_W-1:0]   win_idx_d;
    logic [IDX_W-1:0]   cand;

    // Search starts one past the last grant so every requester gets its turn.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = ptr_q;
        cand      = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_vld_d && in_Req[cand]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand;
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0] wdog_q;
    logic            timeout_q;
`endif

    always_ff @(posedge in_Clk or posedge in_Reset) begin
        if (in_Reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            owner_q   <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            tx_en_q   <= 1'b0;
            tx_byte_q <= '0;
            busy_q    <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wdog_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            grant_q <= '0;
            done_q  <= '0;
            tx_en_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (win_vld_d) begin
                        grant_q   <= NUM_REQ'(1) << win_idx_d;
                        tx_en_q   <= 1'b1;
                        tx_byte_q <= in_Req_Byte[{win_idx_d, 3'b000} +: 8];
                        owner_q   <= win_idx_d;
                        ptr_q     <= win_idx_d;
                        busy_q    <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                    wdog_q  <= '0;
`endif
                    state_q <= S_WAIT_FIN;
                end
                S_WAIT_FIN: begin
                    if (in_TX_Finish) begin
                        done_q  <= NUM_REQ'(1) << owner_q;
                        state_q <= S_RELEASE;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_RELEASE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
                S_RELEASE: begin
                    // Finish is held for two cycles; wait it out so UART_TX is idle again.
                    if (!in_TX_Finish) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_Grant   = grant_q;
    assign out_Done    = done_q;
    assign out_TX_EN   = tx_en_q;
    assign out_TX_Byte = tx_byte_q;
    assign out_Busy    = busy_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign out_Timeout = timeout_q;
`else
    assign out_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single, rotation, back-to-back, abort, timeout.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_byte = '0;
    logic           finish = 1'b0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           tx_en;
    logic [7:0]     tx_byte;
    logic           busy;
    logic           tmo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .in_Clk(clk), .in_Reset(rst), .in_Req(req), .in_Req_Byte(req_byte),
        .out_Grant(grant), .out_Done(done), .out_TX_EN(tx_en), .out_TX_Byte(tx_byte),
        .in_TX_Finish(finish), .out_Busy(busy), .out_Timeout(tmo)
    );

    // Waits (bounded) for the transmit-enable pulse, sampling on falling edges.
    task automatic wait_en(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_en) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    // UART_TX model: finish rises 'gap' cycles later, held 2 cycles; collects done pulses.
    task automatic serve(input int gap, output int n_done, output logic [N-1:0] done_or,
                         output bit idle_ok);
        n_done = 0; done_or = '0; idle_ok = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            if (done != '0) begin n_done++; done_or |= done; end
        end
        finish = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done != '0) begin n_done++; done_or |= done; end
        end
        finish = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done != '0) begin n_done++; done_or |= done; end
            if (!busy) begin
                idle_ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n_en;
        rst = 1'b1; req = '0; finish = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({grant, done, tx_en, tx_byte} !== '0) begin errors++;
            $display("FAIL reset_outputs: got %h required 0", {grant, done, tx_en, tx_byte}); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (tmo !== 1'b0) begin errors++;
            $display("FAIL reset_timeout: got %b required 0", tmo); end
        rst = 1'b0;
        n_en = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_en || busy) n_en++;
        end
        checks++; if (n_en !== 0) begin errors++;
            $display("FAIL idle_no_en: got %0d active cycles required 0", n_en); end
    endtask

    task automatic test_stale_finish();
        int n_act;
        n_act = 0;
        finish = 1'b1;
        repeat (2) begin @(negedge clk); if (done != '0 || busy) n_act++; end
        finish = 1'b0;
        repeat (3) begin @(negedge clk); if (done != '0 || busy) n_act++; end
        checks++; if (n_act !== 0) begin errors++;
            $display("FAIL stale_finish: got %0d active cycles required 0", n_act); end
    endtask

    task automatic test_single();
        bit got, idle_ok;
        int n_done;
        logic [N-1:0] d_or;
        req_byte[23:16] = 8'hA5;
        req = 4'b0100;
        wait_en(got);
        checks++; if (got !== 1'b1) begin errors++;
            $display("FAIL single_en: got no enable required enable"); end
        checks++; if (grant !== 4'b0100) begin errors++;
            $display("FAIL single_grant: got %b required 0100", grant); end
        checks++; if (tx_byte !== 8'hA5) begin errors++;
            $display("FAIL single_byte: got %h required a5", tx_byte); end
        checks++; if (busy !== 1'b1) begin errors++;
            $display("FAIL single_busy: got %b required 1", busy); end
        req = '0;
        serve(10, n_done, d_or, idle_ok);
        checks++; if (n_done !== 1) begin errors++;
            $display("FAIL single_done_count: got %0d required 1", n_done); end
        checks++; if (d_or !== 4'b0100) begin errors++;
            $display("FAIL single_done_value: got %b required 0100", d_or); end
        checks++; if (idle_ok !== 1'b1) begin errors++;
            $display("FAIL single_return_idle: got busy stuck required idle"); end
        checks++; if (tx_byte !== 8'hA5) begin errors++;
            $display("FAIL single_byte_hold: got %h required a5", tx_byte); end
    endtask

    task automatic test_rotation();
        bit got, idle_ok;
        int n_done;
        logic [N-1:0] d_or, g_seen;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_byte = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_en(got);
            g_seen = grant;
            checks++; if (got !== 1'b1) begin errors++;
                $display("FAIL rot_en[%0d]: got no enable required enable", i); end
            checks++; if (grant !== 4'(1 << (i % 4))) begin errors++;
                $display("FAIL rot_grant[%0d]: got %b required %b", i, grant, 4'(1 << (i % 4))); end
            checks++; if (tx_byte !== 8'(16 + (i % 4))) begin errors++;
                $display("FAIL rot_byte[%0d]: got %h required %h", i, tx_byte, 8'(16 + (i % 4))); end
            if (i == 4) req = '0;
            serve(3, n_done, d_or, idle_ok);
            checks++; if (n_done !== 1 || d_or !== g_seen) begin errors++;
                $display("FAIL rot_done[%0d]: got %0d pulses %b required 1 pulse %b",
                         i, n_done, d_or, g_seen); end
        end
    endtask

    task automatic test_back_to_back();
        bit got, idle_ok;
        int n_done;
        logic [N-1:0] d_or;
        req_byte[31:24] = 8'hC3;
        req_byte[15:8]  = 8'h3C;
        req = 4'b1000;
        wait_en(got);
        checks++; if (got !== 1'b1 || grant !== 4'b1000 || tx_byte !== 8'hC3) begin errors++;
            $display("FAIL b2b_first: got %b/%h required 1000/c3", grant, tx_byte); end
        serve(4, n_done, d_or, idle_ok);
        checks++; if (n_done !== 1 || d_or !== 4'b1000) begin errors++;
            $display("FAIL b2b_first_done: got %0d %b required 1 1000", n_done, d_or); end
        wait_en(got);
        checks++; if (got !== 1'b1 || grant !== 4'b1000) begin errors++;
            $display("FAIL b2b_second: got %b required 1000", grant); end
        // Requester 1 joins while busy; it must wait for IDLE, then win over 3.
        req = 4'b1010;
        serve(4, n_done, d_or, idle_ok);
        checks++; if (n_done !== 1 || d_or !== 4'b1000) begin errors++;
            $display("FAIL b2b_second_done: got %0d %b required 1 1000", n_done, d_or); end
        wait_en(got);
        checks++; if (got !== 1'b1 || grant !== 4'b0010 || tx_byte !== 8'h3C) begin errors++;
            $display("FAIL after3_grant1: got %b/%h required 0010/3c", grant, tx_byte); end
        req = 4'b1000;
        serve(4, n_done, d_or, idle_ok);
        checks++; if (n_done !== 1 || d_or !== 4'b0010) begin errors++;
            $display("FAIL after3_done1: got %0d %b required 1 0010", n_done, d_or); end
        wait_en(got);
        checks++; if (got !== 1'b1 || grant !== 4'b1000) begin errors++;
            $display("FAIL after3_grant3: got %b required 1000", grant); end
        req = '0;
        serve(4, n_done, d_or, idle_ok);
        checks++; if (n_done !== 1 || d_or !== 4'b1000 || idle_ok !== 1'b1) begin errors++;
            $display("FAIL after3_done3: got %0d %b required 1 1000", n_done, d_or); end
    endtask

    task automatic test_reset_abort();
        bit got, idle_ok;
        int n_done, n_stray;
        logic [N-1:0] d_or;
        n_stray = 0;
        req_byte[7:0] = 8'h5A;
        req = 4'b0001;
        wait_en(got);
        checks++; if (got !== 1'b1 || grant !== 4'b0001) begin errors++;
            $display("FAIL abort_grant0: got %b required 0001", grant); end
        req = '0;
        repeat (3) begin @(negedge clk); if (done != '0) n_stray++; end
        #2 rst = 1'b1;
        #1;
        checks++; if ({grant, done, tx_en, tx_byte, busy, tmo} !== '0) begin errors++;
            $display("FAIL abort_async_clear: got %h required 0",
                     {grant, done, tx_en, tx_byte, busy, tmo}); end
        @(negedge clk);
        if (done != '0) n_stray++;
        rst = 1'b0;
        req = 4'b1000;
        wait_en(got);
        checks++; if (got !== 1'b1 || grant !== 4'b1000 || tx_byte !== 8'hC3) begin errors++;
            $display("FAIL abort_next_grant: got %b/%h required 1000/c3", grant, tx_byte); end
        req = '0;
        serve(4, n_done, d_or, idle_ok);
        checks++; if (n_stray !== 0) begin errors++;
            $display("FAIL abort_no_done: got %0d pulses required 0", n_stray); end
        checks++; if (n_done !== 1 || d_or !== 4'b1000) begin errors++;
            $display("FAIL abort_next_done: got %0d %b required 1 1000", n_done, d_or); end
    endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit got, idle_ok;
        int n_done, k_to, n_d;
        logic [N-1:0] d_or;
        k_to = -1; n_d = 0;
        req = 4'b0100;
        wait_en(got);
        req = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done != '0) n_d++;
            if (tmo && k_to < 0) k_to = k;
            if (!busy) break;
        end
        checks++; if (k_to !== 17) begin errors++;
            $display("FAIL timeout_cycle: got %0d required 17", k_to); end
        checks++; if (n_d !== 0) begin errors++;
            $display("FAIL timeout_no_done: got %0d required 0", n_d); end
        req = 4'b0010;
        wait_en(got);
        checks++; if (got !== 1'b1 || grant !== 4'b0010) begin errors++;
            $display("FAIL timeout_next_grant: got %b required 0010", grant); end
        req = '0;
        serve(5, n_done, d_or, idle_ok);
        checks++; if (n_done !== 1 || d_or !== 4'b0010) begin errors++;
            $display("FAIL timeout_next_done: got %0d %b required 1 0010", n_done, d_or); end
    endtask
`endif

    initial begin
        test_reset();
        test_stale_finish();
        test_single();
        test_rotation();
        test_back_to_back();
        test_reset_abort();
`ifdef UART_TX_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
